ipram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 1024x32 program SRAM macro between the Z80 instruction-fetch path and a debug/loader port. Each requester gets a byte-wide, 12-bit-addressed view. The block drives the macro's word address, active-low chip select and active-low byte write enables, then returns the selected byte one cycle later. It sits between the CPU bus interface, the debug UART loader and the SRAM macro.

---
 rtl/ipram_arbiter.sv | 131 +++++++++++++
 tb/tb_ipram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipram_arbiter.sv
// Two-port arbiter sharing the 1024x32 program SRAM between CPU fetch and the debug/loader port.
// Optional starvation guard for the debug port: define IPRAM_STARVE_GUARD_EN.
//
// state  | meaning
// IDLE   | no read outstanding
// CPU_RD | CPU read issued last cycle, return its byte now
// DBG_RD | debug read issued last cycle, return its byte now
module ipram_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  output logic        cpu_gnt,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [11:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_gnt,
  output logic [7:0]  dbg_rdata,
  output logic        dbg_rvalid,
  output logic        ram_csb,
  output logic [3:0]  ram_web,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_do
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DBG_RD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  lane_q, lane_nxt;
  logic [7:0]  cpu_rdata_q, dbg_rdata_q;
  logic [7:0]  rd_byte;
  logic        dbg_force;

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
    $error("ipram_arbiter: STARVE_MAX out of range 1..255");
  end

`ifdef IPRAM_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  assign dbg_force = (starve_cnt == 8'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (!dbg_req || dbg_gnt) begin
      starve_cnt <= 8'd0;
    end else if (!dbg_force) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign dbg_force = 1'b0;
`endif

  // CPU has priority except when the debug port has waited its maximum
  assign cpu_gnt = !reset && cpu_req && !(dbg_req && dbg_force);
  assign dbg_gnt = !reset && dbg_req && (!cpu_req || dbg_force);

  always_comb begin
    ram_csb  = 1'b1;
    ram_web  = 4'b1111;
    ram_addr = 10'd0;
    ram_di   = 32'd0;
    if (cpu_gnt) begin
      ram_csb  = 1'b0;
      ram_addr = cpu_addr[11:2];
    end else if (dbg_gnt) begin
      ram_csb  = 1'b0;
      ram_addr = dbg_addr[11:2];
      if (dbg_we) begin
        ram_web = ~(4'b1000 >> dbg_addr[1:0]);
        ram_di  = {4{dbg_wdata}};
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    lane_nxt  = lane_q;
    if (cpu_gnt) begin
      state_nxt = CPU_RD;
      lane_nxt  = cpu_addr[1:0];
    end else if (dbg_gnt && !dbg_we) begin
      state_nxt = DBG_RD;
      lane_nxt  = dbg_addr[1:0];
    end
  end

  // big-endian lanes: byte 0 sits in bits 31:24
  always_comb begin
    rd_byte = ram_do[31:24];
    case (lane_q)
      2'd0:    rd_byte = ram_do[31:24];
      2'd1:    rd_byte = ram_do[23:16];
      2'd2:    rd_byte = ram_do[15:8];
      default: rd_byte = ram_do[7:0];
    endcase
  end

  // a read outstanding when reset arrives is dropped without a pulse
  assign cpu_rvalid = (state == CPU_RD) && !reset;
  assign dbg_rvalid = (state == DBG_RD) && !reset;
  assign cpu_rdata  = cpu_rvalid ? rd_byte : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? rd_byte : dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lane_q      <= 2'd0;
      cpu_rdata_q <= 8'd0;
      dbg_rdata_q <= 8'd0;
    end else begin
      state  <= state_nxt;
      lane_q <= lane_nxt;
      if (cpu_rvalid) cpu_rdata_q <= rd_byte;
      if (dbg_rvalid) dbg_rdata_q <= rd_byte;
    end
  end

endmodule

// File: tb/tb_ipram_arbiter.sv
// Scoreboard bench for ipram_arbiter: byte-array reference memory, grant rules and read-return queues.
`timescale 1ns/1ps
module tb_ipram_arbiter;
  localparam int SMAX = 8;
`ifdef IPRAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [11:0] cpu_addr = '0, dbg_addr = '0;
  logic [7:0]  dbg_wdata = '0;
  logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, ram_csb;
  logic [7:0]  cpu_rdata, dbg_rdata;
  logic [3:0]  ram_web;
  logic [9:0]  ram_addr;
  logic [31:0] ram_di, ram_do;

  always #5 clk = ~clk;

  ipram_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  // SRAM macro model
  logic [31:0] sram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'd0;
    ram_do = 32'd0;
  end
  always @(posedge clk) begin
    if (!ram_csb) begin
      for (int b = 0; b < 4; b++)
        if (!ram_web[b]) sram[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
      if (&ram_web) ram_do <= sram[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: byte-addressed memory, starvation count, return queues
  typedef struct { int cyc; logic [7:0] d; } exp_t;
  logic [7:0] ref_mem [4096];
  exp_t cq[$];
  exp_t dq[$];
  int   m_starve = 0;
  initial for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;

  always @(negedge clk) begin
    logic        ec, ed, e_csb;
    logic [3:0]  e_web;
    logic [9:0]  e_addr;
    logic [31:0] e_di;
    int          lane;
    ec = 1'b0; ed = 1'b0;
    if (!reset) begin
      if (cpu_req && dbg_req) begin
        if (GUARD && m_starve == SMAX) ed = 1'b1;
        else ec = 1'b1;
      end else begin
        ec = cpu_req;
        ed = dbg_req;
      end
    end
    chk("grant", {62'd0, cpu_gnt, dbg_gnt}, {62'd0, ec, ed});
    e_csb = 1'b1; e_web = 4'hF; e_addr = 10'd0; e_di = 32'd0;
    if (ec) begin
      e_csb = 1'b0;
      e_addr = cpu_addr[11:2];
      cq.push_back('{cyc + 1, ref_mem[cpu_addr]});
    end else if (ed) begin
      e_csb = 1'b0;
      e_addr = dbg_addr[11:2];
      if (dbg_we) begin
        lane = int'(dbg_addr[1:0]);
        e_web[3 - lane] = 1'b0;
        e_di = {4{dbg_wdata}};
        ref_mem[dbg_addr] = dbg_wdata;
      end else begin
        dq.push_back('{cyc + 1, ref_mem[dbg_addr]});
      end
    end
    chk("ram_bus", {17'd0, e_csb, e_web, e_addr, e_di} == 64'd0 ? 64'd0 : {17'd0, ram_csb, ram_web, ram_addr, ram_di},
        {17'd0, e_csb, e_web, e_addr, e_di});
    if (reset || !dbg_req || ed) m_starve = 0;
    else if (m_starve < SMAX) m_starve++;
  end

  // monitor: pops expectations whenever a read byte is returned
  logic [7:0] last_c = 8'd0, last_d = 8'd0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("cpu_rvalid_in_reset", {63'd0, cpu_rvalid}, 64'd0);
      chk("dbg_rvalid_in_reset", {63'd0, dbg_rvalid}, 64'd0);
      cq.delete(); dq.delete();
      last_c = 8'd0; last_d = 8'd0;
    end else begin
      if (cpu_rvalid) begin
        if (cq.size() == 0) chk("cpu_rvalid_unexpected", {63'd0, cpu_rvalid}, 64'd0);
        else begin
          e = cq.pop_front();
          chk("cpu_latency", 64'(cyc), 64'(e.cyc));
          chk("cpu_rdata", {56'd0, cpu_rdata}, {56'd0, e.d});
          last_c = e.d;
        end
      end else begin
        if (cq.size() > 0 && cq[0].cyc <= cyc) begin
          void'(cq.pop_front());
          chk("cpu_rvalid_missing", {63'd0, cpu_rvalid}, 64'd1);
        end
        chk("cpu_rdata_hold", {56'd0, cpu_rdata}, {56'd0, last_c});
      end
      if (dbg_rvalid) begin
        if (dq.size() == 0) chk("dbg_rvalid_unexpected", {63'd0, dbg_rvalid}, 64'd0);
        else begin
          e = dq.pop_front();
          chk("dbg_latency", 64'(cyc), 64'(e.cyc));
          chk("dbg_rdata", {56'd0, dbg_rdata}, {56'd0, e.d});
          last_d = e.d;
        end
      end else begin
        if (dq.size() > 0 && dq[0].cyc <= cyc) begin
          void'(dq.pop_front());
          chk("dbg_rvalid_missing", {63'd0, dbg_rvalid}, 64'd1);
        end
        chk("dbg_rdata_hold", {56'd0, dbg_rdata}, {56'd0, last_d});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_op(input logic we, input logic [11:0] a, input logic [7:0] d);
    logic got;
    got = 1'b0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = dbg_gnt;
      step();
    end
    dbg_req = 1'b0;
    chk("dbg_op_granted", {63'd0, got}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic cg, dg;
    int   first_g, second_g;
    repeat (3) step();
    reset = 1'b0;
    step();

    // debug write then read-after-write on the next cycle
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h003; dbg_wdata = 8'hA5;
    @(negedge clk);
    chk("raw_web", {60'd0, ram_web}, 64'hE);
    chk("raw_di", {32'd0, ram_di}, 64'hA5A5A5A5);
    step();
    dbg_we = 1'b0;
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("raw_rvalid", {63'd0, dbg_rvalid}, 64'd1);
    chk("raw_rdata", {56'd0, dbg_rdata}, 64'hA5);
    step();

    // four byte writes, then CPU read of byte 2 of the word
    dbg_op(1'b1, 12'h100, 8'h11);
    dbg_op(1'b1, 12'h101, 8'h22);
    dbg_op(1'b1, 12'h102, 8'h33);
    dbg_op(1'b1, 12'h103, 8'h44);
    cpu_req = 1'b1; cpu_addr = 12'h102;
    @(negedge clk);
    chk("cpu102_gnt", {63'd0, cpu_gnt}, 64'd1);
    chk("cpu102_addr", {54'd0, ram_addr}, 64'h040);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu102_rvalid", {63'd0, cpu_rvalid}, 64'd1);
    chk("cpu102_rdata", {56'd0, cpu_rdata}, 64'h33);
    step();

    // both requesting continuously from cycle 0
    first_g = -1; second_g = -1;
    cpu_req = 1'b1; cpu_addr = 12'h010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h004;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg_gnt) begin
        if (first_g < 0) first_g = k;
        else if (second_g < 0) second_g = k;
      end
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("starve_first", 64'(first_g), GUARD ? 64'd8 : 64'hFFFF_FFFF_FFFF_FFFF);
    chk("starve_second", 64'(second_g), GUARD ? 64'd17 : 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    // alternating CPU / debug reads with no bubble
    dbg_op(1'b1, 12'h000, 8'h5A);
    dbg_op(1'b1, 12'h004, 8'hC3);
    for (int i = 0; i < 8; i++) begin
      cpu_req = (i % 2 == 0); cpu_addr = 12'h000;
      dbg_req = (i % 2 == 1); dbg_we = 1'b0; dbg_addr = 12'h004;
      @(negedge clk);
      chk("alt_csb", {63'd0, ram_csb}, 64'd0);
      if (i > 0) begin
        chk("alt_rvalid", {62'd0, cpu_rvalid, dbg_rvalid}, (i % 2 == 1) ? 64'd2 : 64'd1);
        chk("alt_rdata", (i % 2 == 1) ? {56'd0, cpu_rdata} : {56'd0, dbg_rdata},
            (i % 2 == 1) ? 64'h5A : 64'hC3);
      end
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();

    // reset arriving while a CPU read is outstanding
    cpu_req = 1'b1; cpu_addr = 12'h101;
    @(negedge clk);
    chk("rst_gnt", {63'd0, cpu_gnt}, 64'd1);
    step();
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_rvalid_dropped", {63'd0, cpu_rvalid}, 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {45'd0, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, ram_csb, ram_web},
        {45'd0, 4'b0000, 8'h00, 8'h00, 1'b1, 4'hF});
    step();

    // randomized traffic; requesters hold until granted, occasionally give up
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      cg = cpu_gnt; dg = dbg_gnt;
      step();
      reset = ($urandom_range(0, 299) == 0);
      if (!cpu_req || cg || reset) begin
        cpu_req  = ($urandom_range(0, 3) != 0);
        cpu_addr = 12'($urandom_range(0, 63));
      end else if ($urandom_range(0, 15) == 0) cpu_req = 1'b0;
      if (!dbg_req || dg || reset) begin
        dbg_req   = 1'($urandom_range(0, 1));
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 12'($urandom_range(0, 63));
        dbg_wdata = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) dbg_req = 1'b0;
    end
    reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
